control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 178 +++++++++++++++++
 tb/tb_control_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
//------------------------------------------------------------------------------
// Module      : control_unit
// Description : Five-step microcode sequencer for a 16-bit accumulator CPU;
//               decodes ir[15:12] into bus/register control strobes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic        pc_out,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        mar_write,
    output logic        ram_out,
    output logic        ram_write,
    output logic        ir_write,
    output logic        ir_operand_out,
    output logic        a_write,
    output logic        a_out,
    output logic        b_write,
    output logic        alu_out,
    output logic        alu_sub,
    output logic        flags_write,
    output logic        out_write,
    output logic        halted,
    output logic [2:0]  t_state
);

    localparam logic [2:0] C_T0 = 3'd0;
    localparam logic [2:0] C_T1 = 3'd1;
    localparam logic [2:0] C_T2 = 3'd2;
    localparam logic [2:0] C_T3 = 3'd3;
    localparam logic [2:0] C_T4 = 3'd4;

    localparam logic [3:0] C_OP_LDA = 4'h1;
    localparam logic [3:0] C_OP_ADD = 4'h2;
    localparam logic [3:0] C_OP_SUB = 4'h3;
    localparam logic [3:0] C_OP_STA = 4'h4;
    localparam logic [3:0] C_OP_LDI = 4'h5;
    localparam logic [3:0] C_OP_JMP = 4'h6;
    localparam logic [3:0] C_OP_JC  = 4'h7;
    localparam logic [3:0] C_OP_JZ  = 4'h8;
    localparam logic [3:0] C_OP_OUT = 4'hE;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    logic [2:0] r_t_state_q;
    logic [2:0] w_t_state_d;
    logic       r_halted_q;
    logic       w_halted_d;
    logic [3:0] w_opcode;
    logic       w_unused_operand;

    assign w_opcode         = ir[15:12];
    assign w_unused_operand = ^ir[11:0];

    // HLT freezes the counter at T2 instead of advancing it.
    always_comb begin
        w_t_state_d = r_t_state_q;
        w_halted_d  = r_halted_q;
        if (!r_halted_q) begin
            if ((r_t_state_q == C_T2) && (w_opcode == C_OP_HLT)) begin
                w_halted_d = 1'b1;
            end else if (r_t_state_q >= C_T4) begin
                w_t_state_d = C_T0;
            end else begin
                w_t_state_d = r_t_state_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t_state_q <= C_T0;
            r_halted_q  <= 1'b0;
        end else begin
            r_t_state_q <= w_t_state_d;
            r_halted_q  <= w_halted_d;
        end
    end

    assign t_state = r_t_state_q;
    assign halted  = r_halted_q;

    // rst gates the decode directly so strobes drop without waiting for a clock.
    always_comb begin
        pc_out         = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        mar_write      = 1'b0;
        ram_out        = 1'b0;
        ram_write      = 1'b0;
        ir_write       = 1'b0;
        ir_operand_out = 1'b0;
        a_write        = 1'b0;
        a_out          = 1'b0;
        b_write        = 1'b0;
        alu_out        = 1'b0;
        alu_sub        = 1'b0;
        flags_write    = 1'b0;
        out_write      = 1'b0;
        if (!rst && !r_halted_q) begin
            case (r_t_state_q)
                C_T0: begin
                    pc_out    = 1'b1;
                    mar_write = 1'b1;
                end
                C_T1: begin
                    ram_out  = 1'b1;
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                end
                C_T2: begin
                    case (w_opcode)
                        C_OP_LDA, C_OP_ADD, C_OP_SUB, C_OP_STA: begin
                            ir_operand_out = 1'b1;
                            mar_write      = 1'b1;
                        end
                        C_OP_LDI: begin
                            ir_operand_out = 1'b1;
                            a_write        = 1'b1;
                        end
                        C_OP_JMP: begin
                            ir_operand_out = 1'b1;
                            pc_load        = 1'b1;
                        end
                        C_OP_JC: begin
                            ir_operand_out = 1'b1;
                            pc_load        = flag_c;
                        end
                        C_OP_JZ: begin
                            ir_operand_out = 1'b1;
                            pc_load        = flag_z;
                        end
                        C_OP_OUT: begin
                            a_out     = 1'b1;
                            out_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                C_T3: begin
                    case (w_opcode)
                        C_OP_LDA: begin
                            ram_out = 1'b1;
                            a_write = 1'b1;
                        end
                        C_OP_ADD, C_OP_SUB: begin
                            ram_out = 1'b1;
                            b_write = 1'b1;
                        end
                        C_OP_STA: begin
                            a_out     = 1'b1;
                            ram_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                C_T4: begin
                    if ((w_opcode == C_OP_ADD) || (w_opcode == C_OP_SUB)) begin
                        alu_out     = 1'b1;
                        a_write     = 1'b1;
                        flags_write = 1'b1;
                        alu_sub     = (w_opcode == C_OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_control_unit
// Description : Directed self-checking bench for control_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;

    localparam logic [14:0] C_PC_OUT  = 15'h4000;
    localparam logic [14:0] C_PC_INC  = 15'h2000;
    localparam logic [14:0] C_PC_LOAD = 15'h1000;
    localparam logic [14:0] C_MAR_W   = 15'h0800;
    localparam logic [14:0] C_RAM_OUT = 15'h0400;
    localparam logic [14:0] C_RAM_W   = 15'h0200;
    localparam logic [14:0] C_IR_W    = 15'h0100;
    localparam logic [14:0] C_IR_OP   = 15'h0080;
    localparam logic [14:0] C_A_W     = 15'h0040;
    localparam logic [14:0] C_A_OUT   = 15'h0020;
    localparam logic [14:0] C_B_W     = 15'h0010;
    localparam logic [14:0] C_ALU_OUT = 15'h0008;
    localparam logic [14:0] C_ALU_SUB = 15'h0004;
    localparam logic [14:0] C_FL_W    = 15'h0002;
    localparam logic [14:0] C_OUT_W   = 15'h0001;

    localparam logic [14:0] C_FETCH0 = C_PC_OUT | C_MAR_W;
    localparam logic [14:0] C_FETCH1 = C_RAM_OUT | C_IR_W | C_PC_INC;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        flag_c;
    logic        flag_z;
    logic        pc_out, pc_inc, pc_load, mar_write, ram_out, ram_write, ir_write;
    logic        ir_operand_out, a_write, a_out, b_write, alu_out, alu_sub;
    logic        flags_write, out_write, halted;
    logic [2:0]  t_state;
    logic [14:0] ctl;
    logic [4:0]  bus;

    int checks;
    int errors;

    control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .ir             (ir),
        .flag_c         (flag_c),
        .flag_z         (flag_z),
        .pc_out         (pc_out),
        .pc_inc         (pc_inc),
        .pc_load        (pc_load),
        .mar_write      (mar_write),
        .ram_out        (ram_out),
        .ram_write      (ram_write),
        .ir_write       (ir_write),
        .ir_operand_out (ir_operand_out),
        .a_write        (a_write),
        .a_out          (a_out),
        .b_write        (b_write),
        .alu_out        (alu_out),
        .alu_sub        (alu_sub),
        .flags_write    (flags_write),
        .out_write      (out_write),
        .halted         (halted),
        .t_state        (t_state)
    );

    assign ctl = {pc_out, pc_inc, pc_load, mar_write, ram_out, ram_write, ir_write,
                  ir_operand_out, a_write, a_out, b_write, alu_out, alu_sub,
                  flags_write, out_write};
    assign bus = {pc_out, ram_out, ir_operand_out, a_out, alu_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        checks++;
        if (t_state !== 3'd0 || halted !== 1'b0 || ctl !== 15'h0) begin
            errors++;
            $display("FAIL reset_hold: t_state=%0d halted=%b ctl=%h, want 0/0/0000", t_state, halted, ctl);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (t_state !== 3'd0 || ctl !== C_FETCH0) begin
            errors++;
            $display("FAIL reset_release: t_state=%0d ctl=%h, want 0/%h", t_state, ctl, C_FETCH0);
        end
        // ADD aborted in T3
        ir = 16'h2010;
        repeat (3) @(negedge clk);
        checks++;
        if (t_state !== 3'd3 || ctl !== (C_RAM_OUT | C_B_W)) begin
            errors++;
            $display("FAIL add_t3_pre_reset: t_state=%0d ctl=%h, want 3/%h", t_state, ctl, C_RAM_OUT | C_B_W);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (t_state !== 3'd0 || halted !== 1'b0 || ctl !== 15'h0) begin
            errors++;
            $display("FAIL reset_abort: t_state=%0d halted=%b ctl=%h, want 0/0/0000", t_state, halted, ctl);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (t_state !== 3'd0 || ctl !== C_FETCH0) begin
            errors++;
            $display("FAIL reset_resume: t_state=%0d ctl=%h, want 0/%h", t_state, ctl, C_FETCH0);
        end
        #3;
    endtask

    task automatic test_lda();
        logic [14:0] exp_ctl [0:4];
        exp_ctl[0] = C_FETCH0;
        exp_ctl[1] = C_FETCH1;
        exp_ctl[2] = C_IR_OP | C_MAR_W;
        exp_ctl[3] = C_RAM_OUT | C_A_W;
        exp_ctl[4] = 15'h0;
        ir = 16'h1005;
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (t_state !== 3'(t) || ctl !== exp_ctl[t]) begin
                errors++;
                $display("FAIL lda_t%0d: t_state=%0d ctl=%h, want %0d/%h", t, t_state, ctl, t, exp_ctl[t]);
            end
            @(negedge clk);
        end
        checks++;
        if (t_state !== 3'd0) begin
            errors++;
            $display("FAIL lda_wrap: t_state=%0d, want 0", t_state);
        end
    endtask

    task automatic test_arith();
        logic [15:0] ops [0:1];
        logic [14:0] exp_ctl [0:4];
        ops[0] = 16'h2010;
        ops[1] = 16'h3010;
        for (int k = 0; k < 2; k++) begin
            exp_ctl[0] = C_FETCH0;
            exp_ctl[1] = C_FETCH1;
            exp_ctl[2] = C_IR_OP | C_MAR_W;
            exp_ctl[3] = C_RAM_OUT | C_B_W;
            exp_ctl[4] = C_ALU_OUT | C_A_W | C_FL_W | ((k == 1) ? C_ALU_SUB : 15'h0);
            ir = ops[k];
            for (int t = 0; t < 5; t++) begin
                checks++;
                if (t_state !== 3'(t) || ctl !== exp_ctl[t]) begin
                    errors++;
                    $display("FAIL arith_%h_t%0d: t_state=%0d ctl=%h, want %0d/%h", ops[k], t, t_state, ctl, t, exp_ctl[t]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_cond_jump();
        logic [15:0] ops [0:3];
        logic        fc  [0:3];
        logic        fz  [0:3];
        logic [14:0] exp_t2 [0:3];
        ops[0] = 16'h7020; fc[0] = 1'b0; fz[0] = 1'b1; exp_t2[0] = C_IR_OP;
        ops[1] = 16'h7020; fc[1] = 1'b1; fz[1] = 1'b0; exp_t2[1] = C_IR_OP | C_PC_LOAD;
        ops[2] = 16'h8020; fc[2] = 1'b1; fz[2] = 1'b0; exp_t2[2] = C_IR_OP;
        ops[3] = 16'h8020; fc[3] = 1'b0; fz[3] = 1'b1; exp_t2[3] = C_IR_OP | C_PC_LOAD;
        for (int k = 0; k < 4; k++) begin
            ir = ops[k];
            flag_c = fc[k];
            flag_z = fz[k];
            repeat (2) @(negedge clk);
            checks++;
            if (t_state !== 3'd2 || ctl !== exp_t2[k]) begin
                errors++;
                $display("FAIL jump_%h_c%b_z%b: t_state=%0d ctl=%h, want 2/%h", ops[k], fc[k], fz[k], t_state, ctl, exp_t2[k]);
            end
            repeat (3) @(negedge clk);
        end
        flag_c = 1'b0;
        flag_z = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops [0:3];
        logic [14:0] exp_ctl [0:3][2:4];
        ops[0] = 16'h4033;
        exp_ctl[0][2] = C_IR_OP | C_MAR_W; exp_ctl[0][3] = C_A_OUT | C_RAM_W; exp_ctl[0][4] = 15'h0;
        ops[1] = 16'h5042;
        exp_ctl[1][2] = C_IR_OP | C_A_W;   exp_ctl[1][3] = 15'h0;           exp_ctl[1][4] = 15'h0;
        ops[2] = 16'h6001;
        exp_ctl[2][2] = C_IR_OP | C_PC_LOAD; exp_ctl[2][3] = 15'h0;         exp_ctl[2][4] = 15'h0;
        ops[3] = 16'hE000;
        exp_ctl[3][2] = C_A_OUT | C_OUT_W; exp_ctl[3][3] = 15'h0;           exp_ctl[3][4] = 15'h0;
        for (int k = 0; k < 4; k++) begin
            ir = ops[k];
            checks++;
            if (t_state !== 3'd0 || ctl !== C_FETCH0) begin
                errors++;
                $display("FAIL b2b_%h_t0: t_state=%0d ctl=%h, want 0/%h", ops[k], t_state, ctl, C_FETCH0);
            end
            @(negedge clk);
            checks++;
            if (t_state !== 3'd1 || ctl !== C_FETCH1) begin
                errors++;
                $display("FAIL b2b_%h_t1: t_state=%0d ctl=%h, want 1/%h", ops[k], t_state, ctl, C_FETCH1);
            end
            @(negedge clk);
            for (int t = 2; t < 5; t++) begin
                checks++;
                if (t_state !== 3'(t) || ctl !== exp_ctl[k][t]) begin
                    errors++;
                    $display("FAIL b2b_%h_t%0d: t_state=%0d ctl=%h, want %0d/%h", ops[k], t, t_state, ctl, t, exp_ctl[k][t]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_illegal();
        ir = 16'hA123;
        repeat (2) @(negedge clk);
        for (int t = 2; t < 5; t++) begin
            checks++;
            if (t_state !== 3'(t) || ctl !== 15'h0) begin
                errors++;
                $display("FAIL illegal_t%0d: t_state=%0d ctl=%h, want %0d/0000", t, t_state, ctl, t);
            end
            @(negedge clk);
        end
        checks++;
        if (t_state !== 3'd0) begin
            errors++;
            $display("FAIL illegal_wrap: t_state=%0d, want 0", t_state);
        end
        // Bus-driver exclusivity across every non-halting opcode and flag setting
        for (int op = 0; op < 15; op++) begin
            ir = {4'(op), 12'hFFF};
            flag_c = op[0];
            flag_z = ~op[0];
            for (int t = 0; t < 5; t++) begin
                checks++;
                if ($countones(bus) > 1) begin
                    errors++;
                    $display("FAIL bus_onehot_op%h_t%0d: drivers=%b, want at most one", op[3:0], t, bus);
                end
                @(negedge clk);
            end
        end
        flag_c = 1'b0;
        flag_z = 1'b0;
    endtask

    task automatic test_halt();
        bit bad;
        ir = 16'hF000;
        repeat (2) @(negedge clk);
        checks++;
        if (t_state !== 3'd2 || halted !== 1'b0 || ctl !== 15'h0) begin
            errors++;
            $display("FAIL hlt_t2: t_state=%0d halted=%b ctl=%h, want 2/0/0000", t_state, halted, ctl);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ir = (i[0]) ? 16'h2010 : 16'h6001;
            #1;
            checks++;
            if (t_state !== 3'd2 || halted !== 1'b1 || ctl !== 15'h0) begin
                errors++;
                bad = 1'b1;
                $display("FAIL hlt_hold_%0d: t_state=%0d halted=%b ctl=%h, want 2/1/0000", i, t_state, halted, ctl);
            end
            if (bad) break;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || t_state !== 3'd0 || ctl !== 15'h0) begin
            errors++;
            $display("FAIL hlt_reset: halted=%b t_state=%0d ctl=%h, want 0/0/0000", halted, t_state, ctl);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || t_state !== 3'd0 || ctl !== C_FETCH0) begin
            errors++;
            $display("FAIL hlt_resume: halted=%b t_state=%0d ctl=%h, want 0/0/%h", halted, t_state, ctl, C_FETCH0);
        end
        @(negedge clk);
        checks++;
        if (t_state !== 3'd1 || ctl !== C_FETCH1) begin
            errors++;
            $display("FAIL hlt_resume_t1: t_state=%0d ctl=%h, want 1/%h", t_state, ctl, C_FETCH1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        ir     = 16'h0000;
        flag_c = 1'b0;
        flag_z = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_lda();
        test_arith();
        test_cond_jump();
        test_back_to_back();
        test_illegal();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
